// File: rtl/weight_fetch_ctrl.sv
// Weight bank sequencer: optional whole-layer load, then streams num_words weights
// from base_addr to the PE datapath through a 2-entry skid buffer with read-data bypass.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD      | load strobe to the bank (1 cycle)
// LOAD_WAIT | settle cycle after the load strobe
// FETCH     | issuing reads while buffer space allows
// DRAIN     | all reads issued, waiting for the last handshake
module weight_fetch_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            layer_id,
  input  logic                  reload,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_csen,
  output logic [3:0]            mem_layer_cnt,
  output logic                  mem_wrenb,
  output logic                  mem_rdena,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  input  logic [DATA_WIDTH-1:0] mem_data_a,
  output logic                  wt_valid,
  output logic [DATA_WIDTH-1:0] wt_data,
  output logic                  wt_last,
  input  logic                  wt_ready
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic [2:0]            state;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  popped;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            cnt;
  logic                  done_q;

  logic [2:0]            outstanding;
  logic                  issue;
  logic                  fifo_ne;
  logic                  pop;
  logic                  push;
  logic                  fifo_pop;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] head;

  // Space is judged on registered occupancy only, so a pop frees a slot one cycle later.
  assign outstanding = {1'b0, cnt} + {2'b00, inflight};
  assign issue       = (state == S_FETCH) && (outstanding < 3'd2);
  assign fifo_ne     = (cnt != 2'd0);
  assign is_last     = (popped == len - LEN_ONE);

  // Returning read data bypasses the empty buffer so a streaming consumer sees no bubble.
  always_comb begin
    head = '0;
    if (fifo_ne)
      head = fifo[rd_idx];
    else if (inflight)
      head = mem_data_a;
  end

  assign wt_valid = fifo_ne | inflight;
  assign wt_data  = head;
  assign wt_last  = wt_valid & is_last;
  assign pop      = wt_valid & wt_ready;
  assign push     = inflight & ~(~fifo_ne & pop);
  assign fifo_pop = pop & fifo_ne;

  assign busy       = (state != S_IDLE);
  assign done       = done_q;
  assign mem_wrenb  = (state == S_LOAD);
  assign mem_rdena  = issue;
  assign mem_csen   = mem_wrenb | mem_rdena;
  assign mem_addr_a = rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len           <= '0;
      issued        <= '0;
      popped        <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      fifo[0]       <= '0;
      fifo[1]       <= '0;
      wr_idx        <= 1'b0;
      rd_idx        <= 1'b0;
      cnt           <= 2'd0;
      done_q        <= 1'b0;
      mem_layer_cnt <= 4'd0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && abort) begin
        // A read issued this cycle is dropped by clearing inflight.
        state    <= S_IDLE;
        issued   <= '0;
        popped   <= '0;
        inflight <= 1'b0;
        wr_idx   <= 1'b0;
        rd_idx   <= 1'b0;
        cnt      <= 2'd0;
      end else begin
        inflight <= issue;
        if (push) begin
          fifo[wr_idx] <= mem_data_a;
          wr_idx       <= ~wr_idx;
        end
        if (fifo_pop)
          rd_idx <= ~rd_idx;
        cnt <= cnt + {1'b0, push} - {1'b0, fifo_pop};
        if (pop)
          popped <= popped + LEN_ONE;
        if (issue) begin
          rd_ptr <= rd_ptr + ADDR_ONE;
          issued <= issued + LEN_ONE;
        end
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              len    <= num_words;
              rd_ptr <= base_addr;
              issued <= '0;
              popped <= '0;
              if (num_words == '0) begin
                done_q <= 1'b1;
              end else if (reload) begin
                state         <= S_LOAD;
                mem_layer_cnt <= layer_id;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          S_LOAD:      state <= S_LOAD_WAIT;
          S_LOAD_WAIT: state <= S_FETCH;
          S_FETCH: begin
            if (issue && (issued + LEN_ONE == len))
              state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (pop && is_last) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: transaction-count reference model checked every cycle,
// plus directed timing/address literals and randomized backpressure/abort traffic.
module tb_weight_fetch_ctrl;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LW = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, reload = 1'b0, abort = 1'b0, wt_ready = 1'b0;
  logic [3:0] layer_id = '0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic busy, done, mem_csen, mem_wrenb, mem_rdena, wt_valid, wt_last;
  logic [3:0] mem_layer_cnt;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_data_a, wt_data;

  logic [7:0] mem_img [2048];
  int vectors = 0, errors = 0, cyc = 0;

  weight_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_id(layer_id), .reload(reload),
    .base_addr(base_addr), .num_words(num_words), .abort(abort), .busy(busy), .done(done),
    .mem_csen(mem_csen), .mem_layer_cnt(mem_layer_cnt), .mem_wrenb(mem_wrenb),
    .mem_rdena(mem_rdena), .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_last(wt_last), .wt_ready(wt_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: registered read, zero when not reading.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mem_data_a <= '0;
    else        mem_data_a <= mem_rdena ? mem_img[mem_addr_a] : '0;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a command is just counts of reads issued and words handed over.
  bit m_busy = 0, m_done_due = 0, m_reload = 0;
  int m_n = 0, m_reads = 0, m_pops = 0, m_t = 0;
  logic [AW-1:0] m_base = '0;
  logic [3:0] layer_exp = '0;
  bit e_rd, e_valid, e_wr, m_pop, nd;
  logic [AW-1:0] e_addr, e_idx;
  bit stalled = 0;
  logic [DW-1:0] stall_data;
  logic stall_last;

  // Per-command event log (cycle offsets from the start cycle), taken from the DUT.
  int t_start = 0, r_first_rd = -1, r_first_valid = -1, r_last = -1, r_done = -1;
  int r_wr = -1, r_wrs = 0, r_rds = 0, r_wr_layer = -1;
  logic [AW-1:0] r_addrs [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);       check("rst_done", done, 0);
      check("rst_csen", mem_csen, 0);   check("rst_wrenb", mem_wrenb, 0);
      check("rst_rdena", mem_rdena, 0); check("rst_valid", wt_valid, 0);
      check("rst_last", wt_last, 0);    check("rst_layer", mem_layer_cnt, 0);
      check("rst_addr", mem_addr_a, 0); check("rst_data", wt_data, 0);
      m_busy = 0; m_done_due = 0; layer_exp = '0; stalled = 0;
    end else begin
      e_rd    = m_busy && (m_t >= (m_reload ? 3 : 1)) && (m_reads < m_n) && ((m_reads - m_pops) < 2);
      e_valid = m_busy && (m_reads > m_pops);
      e_wr    = m_busy && m_reload && (m_t == 1);
      check("busy", busy, m_busy);
      check("done", done, m_done_due);
      check("mem_wrenb", mem_wrenb, e_wr);
      check("mem_layer_cnt", mem_layer_cnt, layer_exp);
      check("mem_csen", mem_csen, mem_rdena | mem_wrenb);
      check("mem_rdena", mem_rdena, e_rd);
      if (e_rd && mem_rdena) begin
        e_addr = m_base + AW'(m_reads);
        check("mem_addr_a", mem_addr_a, e_addr);
      end
      check("wt_valid", wt_valid, e_valid);
      if (e_valid && wt_valid) begin
        e_idx = m_base + AW'(m_pops);
        check("wt_data", wt_data, mem_img[e_idx]);
        check("wt_last", wt_last, m_pops == m_n - 1);
      end else begin
        check("wt_last_idle", wt_last, 0);
      end
      if (stalled) begin
        check("stall_valid", wt_valid, 1);
        check("stall_data", wt_data, stall_data);
        check("stall_last", wt_last, stall_last);
      end

      if (mem_rdena) begin
        if (r_first_rd < 0) r_first_rd = cyc - t_start;
        r_rds++;
        r_addrs.push_back(mem_addr_a);
      end
      if (mem_wrenb) begin
        if (r_wr < 0) r_wr = cyc - t_start;
        r_wrs++;
        r_wr_layer = mem_layer_cnt;
      end
      if (wt_valid && r_first_valid < 0) r_first_valid = cyc - t_start;
      if (wt_valid && wt_ready && wt_last) r_last = cyc - t_start;
      if (done && r_done < 0) r_done = cyc - t_start;

      m_pop = e_valid && wt_ready;
      stalled = wt_valid && !wt_ready && !(m_busy && abort);
      stall_data = wt_data;
      stall_last = wt_last;
      nd = 0;
      if (m_busy && abort) begin
        m_busy = 0;
      end else if (m_busy) begin
        if (e_rd) m_reads++;
        if (m_pop) m_pops++;
        m_t++;
        if (m_pop && m_pops == m_n) begin
          m_busy = 0;
          nd = 1;
        end
      end else if (start && !abort) begin
        t_start = cyc; r_first_rd = -1; r_first_valid = -1; r_last = -1; r_done = -1;
        r_wr = -1; r_wrs = 0; r_rds = 0; r_wr_layer = -1; r_addrs.delete();
        m_base = base_addr; m_n = int'(num_words); m_reload = reload;
        m_reads = 0; m_pops = 0; m_t = 1;
        if (num_words == '0) nd = 1;
        else begin
          m_busy = 1;
          if (reload) layer_exp = layer_id;
        end
      end
      m_done_due = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit rl, input logic [3:0] lid, input logic [AW-1:0] b, input int n);
    start = 1'b1; reload = rl; layer_id = lid; base_addr = b; num_words = LW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, input bit rand_ready, input int abort_odds);
    int k = 0;
    while ((m_busy || m_done_due) && k < budget) begin
      if (rand_ready) wt_ready = 1'($urandom_range(0, 1));
      if (abort_odds > 0) abort = ($urandom_range(0, abort_odds - 1) == 0);
      tick();
      abort = 1'b0;
      k++;
    end
    if (k >= budget) check("timeout", k, 0);
    tick();
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2048; i++) mem_img[i] = 8'($urandom);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Straight stream, no reload
    wt_ready = 1'b1;
    issue_cmd(1'b0, 4'd0, 11'h010, 4);
    run_to_idle(50, 1'b0, 0);
    check("t1_first_rd", r_first_rd, 1);
    check("t1_first_valid", r_first_valid, 2);
    check("t1_last", r_last, 5);
    check("t1_done", r_done, 6);
    check("t1_reads", r_rds, 4);
    for (int i = 0; i < 4 && i < r_addrs.size(); i++) check("t1_addr", r_addrs[i], 16 + i);

    // Reload first
    issue_cmd(1'b1, 4'd3, 11'h100, 2);
    run_to_idle(50, 1'b0, 0);
    check("t2_wrenb_at", r_wr, 1);
    check("t2_wrenb_count", r_wrs, 1);
    check("t2_layer", r_wr_layer, 3);
    check("t2_first_rd", r_first_rd, 3);
    check("t2_first_valid", r_first_valid, 4);
    check("t2_done", r_done, 6);

    // Address wrap
    issue_cmd(1'b0, 4'd0, 11'h7FE, 4);
    run_to_idle(50, 1'b0, 0);
    check("wrap_reads", r_rds, 4);
    if (r_addrs.size() == 4) begin
      check("wrap_a0", r_addrs[0], 11'h7FE);
      check("wrap_a1", r_addrs[1], 11'h7FF);
      check("wrap_a2", r_addrs[2], 11'h000);
      check("wrap_a3", r_addrs[3], 11'h001);
    end

    // Zero length
    issue_cmd(1'b1, 4'd5, 11'h020, 0);
    run_to_idle(10, 1'b0, 0);
    check("zero_done", r_done, 1);
    check("zero_reads", r_rds, 0);
    check("zero_wrenb", r_wrs, 0);

    // 16 words under random backpressure
    for (int r = 0; r < 6; r++) begin
      issue_cmd(1'($urandom), 4'($urandom), AW'($urandom), 16);
      run_to_idle(400, 1'b1, 0);
      check("bp_reads", r_rds, 16);
    end

    // Abort after 3 of 10 words
    wt_ready = 1'b1;
    issue_cmd(1'b0, 4'd0, 11'h200, 10);
    k = 0;
    while (m_pops < 3 && k < 50) begin tick(); k++; end
    if (k >= 50) check("abort_wait_timeout", k, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", wt_valid, 0);
    check("abort_busy", busy, 0);
    repeat (3) tick();
    check("abort_no_done", r_done, -1);

    // Clean run after abort, with a start pulsed while busy
    issue_cmd(1'b0, 4'd0, 11'h300, 6);
    tick();
    issue_cmd(1'b1, 4'd7, 11'h000, 3);
    run_to_idle(100, 1'b0, 0);
    check("busy_start_reads", r_rds, 6);
    check("busy_start_wrenb", r_wrs, 0);
    if (r_addrs.size() > 0) check("busy_start_addr0", r_addrs[0], 11'h300);

    // Random mix with occasional aborts
    for (int r = 0; r < 25; r++) begin
      issue_cmd(1'($urandom), 4'($urandom), AW'($urandom), $urandom_range(0, 40));
      run_to_idle(600, 1'b1, 40);
    end

    // Asynchronous reset mid-command
    wt_ready = 1'b1;
    issue_cmd(1'b1, 4'd9, 11'h400, 10);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_valid", wt_valid, 0);
    check("areset_rdena", mem_rdena, 0);
    check("areset_layer", mem_layer_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    issue_cmd(1'b0, 4'd0, 11'h050, 3);
    run_to_idle(50, 1'b0, 0);
    check("post_reset_done", r_done, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
